// File: rtl/xadac_pkg.sv
// xadac shared types and defaults.
// Used by the request arbiter and its skid stage.
package xadac_pkg;

  localparam int unsigned NumReqDef      = 4;
  localparam int unsigned MaxInflightDef = 4;
  localparam int unsigned XadacIdxW      = $clog2(NumReqDef);

  typedef logic [XadacIdxW-1:0] xadac_idx_t;

endpackage

// File: rtl/xadac_skid.sv
// xadac skid register: one-cycle, full-throughput
// valid/ready stage with a registered slave ready.
module xadac_skid
  import xadac_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic [W-1:0] slv_data,
  input  logic         slv_valid,
  output logic         slv_ready,
  output logic [W-1:0] mst_data,
  output logic         mst_valid,
  input  logic         mst_ready
);

  logic [W-1:0] m_data;
  logic [W-1:0] s_data;
  logic         m_valid;
  logic         s_valid;
  logic         in_hs;

  assign slv_ready = !s_valid;
  assign in_hs     = slv_valid && slv_ready;
  assign mst_data  = m_data;
  assign mst_valid = m_valid;

  // Main register refills from the skid slot first, else from input.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_data  <= '0;
      s_data  <= '0;
      m_valid <= 1'b0;
      s_valid <= 1'b0;
    end else if (mst_ready || !m_valid) begin
      if (s_valid) begin
        m_data  <= s_data;
        m_valid <= 1'b1;
        s_valid <= 1'b0;
      end else begin
        m_data  <= slv_data;
        m_valid <= in_hs;
      end
    end else if (in_hs) begin
      s_data  <= slv_data;
      s_valid <= 1'b1;
    end
  end

endmodule

// File: rtl/xadac_req_arbiter.sv
// xadac request arbiter: round-robin over NumReq
// requesters with a per-requester in-flight limit.
module xadac_req_arbiter
  import xadac_pkg::*;
#(
  parameter int unsigned NumReq      = NumReqDef,
  parameter int unsigned MaxInflight = MaxInflightDef,
  parameter bit          OutReg      = 1'b0,
  parameter type         DataT       = logic
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  DataT [NumReq-1:0]         slv_data,
  input  logic [NumReq-1:0]         slv_valid,
  output logic [NumReq-1:0]         slv_ready,
  output DataT                      mst_data,
  output logic [$clog2(NumReq)-1:0] mst_idx,
  output logic                      mst_valid,
  input  logic                      mst_ready,
  input  logic                      rsp_valid,
  input  logic [$clog2(NumReq)-1:0] rsp_idx,
  output logic [NumReq-1:0]         inflight_full,
  output logic                      err
);

  localparam int unsigned IdxW = $clog2(NumReq);
  localparam int unsigned CntW = $clog2(MaxInflight + 1);
  localparam int unsigned DW   = $bits(DataT);

  typedef logic [IdxW-1:0] idx_t;
  typedef logic [IdxW:0]   sum_t;
  typedef logic [CntW-1:0] cnt_t;

  idx_t              ptr;
  idx_t              lidx;
  logic              lock;
  cnt_t              cnt [NumReq];
  logic [NumReq-1:0] elig;
  logic [NumReq-1:0] rot;
  idx_t              off;
  sum_t              sum;
  idx_t              winner;
  logic              bad_rsp;

  logic int_valid;
  logic int_ready;
  logic int_hs;
  DataT int_data;
  idx_t int_idx;

  // Eligibility uses the registered counts only.
  always_comb begin
    elig = '0;
    for (int i = 0; i < NumReq; i++) begin
      elig[i] = slv_valid[i] && (cnt[i] < cnt_t'(MaxInflight));
    end
  end

  // Rotate by ptr, take lowest set bit, rotate back.
  always_comb begin
    rot = NumReq'({elig, elig} >> ptr);
    off = '0;
    for (int k = NumReq - 1; k >= 0; k--) begin
      if (rot[k]) off = idx_t'(k);
    end
    sum = {1'b0, ptr} + {1'b0, off};
    if (sum >= sum_t'(NumReq)) sum = sum - sum_t'(NumReq);
    winner = lock ? lidx : idx_t'(sum);
  end

  assign int_valid = lock || (|elig);
  assign int_hs    = int_valid && int_ready;
  assign int_data  = slv_data[winner];
  assign int_idx   = winner;

  // Only the winner sees ready.
  always_comb begin
    slv_ready = '0;
    for (int i = 0; i < NumReq; i++) begin
      slv_ready[i] = int_ready && int_valid && (winner == idx_t'(i));
    end
  end

  // A retire is bad unless it hits an existing nonzero counter.
  always_comb begin
    bad_rsp = rsp_valid;
    for (int i = 0; i < NumReq; i++) begin
      if (rsp_idx == idx_t'(i) && cnt[i] != '0) bad_rsp = 1'b0;
    end
  end

  // Pointer advance, presented-request lock and sticky error.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ptr  <= '0;
      lock <= 1'b0;
      lidx <= '0;
      err  <= 1'b0;
    end else begin
      if (int_hs) begin
        ptr  <= (winner == idx_t'(NumReq - 1)) ? '0 : winner + idx_t'(1);
        lock <= 1'b0;
      end else if (int_valid) begin
        lock <= 1'b1;
        lidx <= winner;
      end
      if (bad_rsp) err <= 1'b1;
    end
  end

  for (genvar g = 0; g < NumReq; g++) begin : g_cnt
    cnt_t q;
    logic inc;
    logic dec;

    assign inc = int_hs && (winner == idx_t'(g));
    assign dec = rsp_valid && (rsp_idx == idx_t'(g)) && (q != '0);

    // Grant adds, retire removes; both together cancel.
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        q <= '0;
      end else if (inc && !dec) begin
        q <= q + cnt_t'(1);
      end else if (dec && !inc) begin
        q <= q - cnt_t'(1);
      end
    end

    assign cnt[g]           = q;
    assign inflight_full[g] = (q == cnt_t'(MaxInflight));
  end

  if (OutReg) begin : g_out_reg
    logic [DW+IdxW-1:0] sd;
    logic [DW+IdxW-1:0] md;

    assign sd = {int_data, int_idx};

    xadac_skid #(
      .W(DW + IdxW)
    ) u_skid (
      .clk      (clk),
      .rstn     (rstn),
      .slv_data (sd),
      .slv_valid(int_valid),
      .slv_ready(int_ready),
      .mst_data (md),
      .mst_valid(mst_valid),
      .mst_ready(mst_ready)
    );

    assign {mst_data, mst_idx} = md;
  end else begin : g_out_direct
    assign mst_data  = int_data;
    assign mst_idx   = int_idx;
    assign mst_valid = int_valid;
    assign int_ready = mst_ready;
  end

endmodule

// File: tb/tb_xadac_req_arbiter.sv
// Bench for xadac_req_arbiter: direct and
// skid-registered master sides.
module tb_xadac_req_arbiter;

  typedef struct packed {
    logic [1:0] idx;
    logic [7:0] data;
  } txn_t;

  logic clk;
  int   checks;
  int   errors;
  txn_t exp_q[$];
  txn_t obs_q[$];
  txn_t e;
  txn_t o;

  logic            rstn0;
  logic [3:0][7:0] slv_data0;
  logic [3:0]      slv_valid0;
  logic [3:0]      slv_ready0;
  logic [7:0]      mst_data0;
  logic [1:0]      mst_idx0;
  logic            mst_valid0;
  logic            mst_ready0;
  logic            rsp_valid0;
  logic [1:0]      rsp_idx0;
  logic [3:0]      inflight_full0;
  logic            err0;

  logic            rstn1;
  logic [3:0][7:0] slv_data1;
  logic [3:0]      slv_valid1;
  logic [3:0]      slv_ready1;
  logic [7:0]      mst_data1;
  logic [1:0]      mst_idx1;
  logic            mst_valid1;
  logic            mst_ready1;
  logic            rsp_valid1;
  logic [1:0]      rsp_idx1;
  logic [3:0]      inflight_full1;
  logic            err1;

  xadac_req_arbiter #(
    .NumReq(4), .MaxInflight(2), .OutReg(1'b0), .DataT(logic [7:0])
  ) dut0 (
    .clk(clk), .rstn(rstn0),
    .slv_data(slv_data0), .slv_valid(slv_valid0), .slv_ready(slv_ready0),
    .mst_data(mst_data0), .mst_idx(mst_idx0),
    .mst_valid(mst_valid0), .mst_ready(mst_ready0),
    .rsp_valid(rsp_valid0), .rsp_idx(rsp_idx0),
    .inflight_full(inflight_full0), .err(err0)
  );

  xadac_req_arbiter #(
    .NumReq(4), .MaxInflight(4), .OutReg(1'b1), .DataT(logic [7:0])
  ) dut1 (
    .clk(clk), .rstn(rstn1),
    .slv_data(slv_data1), .slv_valid(slv_valid1), .slv_ready(slv_ready1),
    .mst_data(mst_data1), .mst_idx(mst_idx1),
    .mst_valid(mst_valid1), .mst_ready(mst_ready1),
    .rsp_valid(rsp_valid1), .rsp_idx(rsp_idx1),
    .inflight_full(inflight_full1), .err(err1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rstn0 && mst_valid0 && mst_ready0)
      obs_q.push_back(txn_t'({mst_idx0, mst_data0}));
  end

  task automatic do_reset0();
    rstn0 = 1'b0;
    slv_valid0 = '0;
    mst_ready0 = 1'b0;
    rsp_valid0 = 1'b0;
    rsp_idx0 = '0;
    @(posedge clk); #1;
    rstn0 = 1'b1;
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic do_reset1();
    rstn1 = 1'b0;
    slv_valid1 = '0;
    mst_ready1 = 1'b0;
    rsp_valid1 = 1'b0;
    rsp_idx1 = '0;
    @(posedge clk); #1;
    rstn1 = 1'b1;
  endtask

  task automatic test_reset();
    rstn0 = 1'b0;
    slv_valid0 = '0;
    mst_ready0 = 1'b1;
    rsp_valid0 = 1'b0;
    @(negedge clk);
    checks++;
    if (mst_valid0 !== 1'b0 || slv_ready0 !== 4'b0 ||
        inflight_full0 !== 4'b0 || err0 !== 1'b0 || dut0.ptr !== 2'd0) begin
      errors++;
      $display("FAIL reset: mst_valid=%b slv_ready=%b full=%b err=%b ptr=%0d, required 0 0000 0000 0 0",
               mst_valid0, slv_ready0, inflight_full0, err0, dut0.ptr);
    end
    @(posedge clk); #1;
    rstn0 = 1'b1;
    mst_ready0 = 1'b0;
  endtask

  task automatic test_round_robin();
    do_reset0();
    for (int i = 0; i < 4; i++)
      exp_q.push_back(txn_t'({2'(i), 8'hA0 + 8'(i)}));
    exp_q.push_back(txn_t'({2'd0, 8'hA0}));
    slv_valid0 = 4'hF;
    mst_ready0 = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
    end
    slv_valid0 = '0;
    @(negedge clk);
    checks++;
    if (obs_q.size() != 5) begin
      errors++;
      $display("FAIL rr_count: got %0d grants, required 5", obs_q.size());
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++;
        $display("FAIL rr_grant: missing grant, required idx %0d", e.idx);
        break;
      end
      o = obs_q.pop_front();
      if (o !== e) begin
        errors++;
        $display("FAIL rr_grant: got idx %0d data %h, required idx %0d data %h",
                 o.idx, o.data, e.idx, e.data);
      end
    end
    checks++;
    if (dut0.ptr !== 2'd1) begin
      errors++;
      $display("FAIL rr_ptr: got %0d, required 1", dut0.ptr);
    end
  endtask

  task automatic test_backpressure();
    do_reset0();
    slv_valid0 = 4'b0110;
    mst_ready0 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (mst_valid0 !== 1'b1 || mst_idx0 !== 2'd1 || mst_data0 !== 8'hA1) begin
        errors++;
        $display("FAIL bp_stable: cycle %0d valid=%b idx=%0d data=%h, required 1 1 a1",
                 k, mst_valid0, mst_idx0, mst_data0);
      end
      @(posedge clk); #1;
      if (k == 0) slv_valid0 = 4'b0111;
    end
    mst_ready0 = 1'b1;
    exp_q.push_back(txn_t'({2'd1, 8'hA1}));
    exp_q.push_back(txn_t'({2'd2, 8'hA2}));
    repeat (2) begin
      @(posedge clk); #1;
    end
    slv_valid0 = '0;
    mst_ready0 = 1'b0;
    @(negedge clk);
    checks++;
    if (obs_q.size() != 2) begin
      errors++;
      $display("FAIL bp_count: got %0d grants, required 2", obs_q.size());
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++;
        $display("FAIL bp_grant: missing grant, required idx %0d", e.idx);
        break;
      end
      o = obs_q.pop_front();
      if (o !== e) begin
        errors++;
        $display("FAIL bp_grant: got idx %0d data %h, required idx %0d data %h",
                 o.idx, o.data, e.idx, e.data);
      end
    end
  endtask

  task automatic test_inflight_limit();
    do_reset0();
    slv_valid0 = 4'b0001;
    mst_ready0 = 1'b1;
    exp_q.push_back(txn_t'({2'd0, 8'hA0}));
    exp_q.push_back(txn_t'({2'd0, 8'hA0}));
    repeat (4) begin
      @(posedge clk); #1;
    end
    @(negedge clk);
    checks++;
    if (slv_ready0[0] !== 1'b0 || inflight_full0[0] !== 1'b1 || obs_q.size() != 2) begin
      errors++;
      $display("FAIL limit_full: ready=%b full=%b grants=%0d, required 0 1 2",
               slv_ready0[0], inflight_full0[0], obs_q.size());
    end
    @(posedge clk); #1;
    rsp_valid0 = 1'b1;
    rsp_idx0 = 2'd0;
    @(negedge clk);
    checks++;
    if (slv_ready0[0] !== 1'b0) begin
      errors++;
      $display("FAIL limit_same_cycle: ready=%b, required 0", slv_ready0[0]);
    end
    @(posedge clk); #1;
    rsp_valid0 = 1'b0;
    exp_q.push_back(txn_t'({2'd0, 8'hA0}));
    @(negedge clk);
    checks++;
    if (slv_ready0[0] !== 1'b1 || inflight_full0[0] !== 1'b0) begin
      errors++;
      $display("FAIL limit_freed: ready=%b full=%b, required 1 0",
               slv_ready0[0], inflight_full0[0]);
    end
    @(posedge clk); #1;
    slv_valid0 = '0;
    @(negedge clk);
    checks++;
    if (inflight_full0[0] !== 1'b1 || err0 !== 1'b0) begin
      errors++;
      $display("FAIL limit_refull: full=%b err=%b, required 1 0",
               inflight_full0[0], err0);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++;
        $display("FAIL limit_grant: missing grant, required idx %0d", e.idx);
        break;
      end
      o = obs_q.pop_front();
      if (o !== e) begin
        errors++;
        $display("FAIL limit_grant: got idx %0d data %h, required idx %0d data %h",
                 o.idx, o.data, e.idx, e.data);
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      errors++;
      $display("FAIL limit_extra: %0d extra grants, required 0", obs_q.size());
    end
  endtask

  task automatic test_simul_retire();
    do_reset0();
    slv_valid0 = 4'b0100;
    mst_ready0 = 1'b1;
    exp_q.push_back(txn_t'({2'd2, 8'hA2}));
    @(posedge clk); #1;
    checks++;
    if (dut0.cnt[2] !== 2'd1) begin
      errors++;
      $display("FAIL simul_pre: cnt2=%0d, required 1", dut0.cnt[2]);
    end
    rsp_valid0 = 1'b1;
    rsp_idx0 = 2'd2;
    exp_q.push_back(txn_t'({2'd2, 8'hA2}));
    @(posedge clk); #1;
    rsp_valid0 = 1'b0;
    slv_valid0 = '0;
    mst_ready0 = 1'b0;
    @(negedge clk);
    checks++;
    if (dut0.cnt[2] !== 2'd1 || err0 !== 1'b0) begin
      errors++;
      $display("FAIL simul_cnt: cnt2=%0d err=%b, required 1 0", dut0.cnt[2], err0);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++;
        $display("FAIL simul_grant: missing grant, required idx %0d", e.idx);
        break;
      end
      o = obs_q.pop_front();
      if (o !== e) begin
        errors++;
        $display("FAIL simul_grant: got idx %0d data %h, required idx %0d data %h",
                 o.idx, o.data, e.idx, e.data);
      end
    end
  endtask

  task automatic test_bad_retire();
    @(posedge clk); #1;
    rsp_valid0 = 1'b1;
    rsp_idx0 = 2'd3;
    @(negedge clk);
    checks++;
    if (err0 !== 1'b0) begin
      errors++;
      $display("FAIL bad_before: err=%b, required 0", err0);
    end
    @(posedge clk); #1;
    rsp_valid0 = 1'b0;
    @(negedge clk);
    checks++;
    if (err0 !== 1'b1 || dut0.cnt[3] !== 2'd0 || dut0.cnt[2] !== 2'd1) begin
      errors++;
      $display("FAIL bad_set: err=%b cnt3=%0d cnt2=%0d, required 1 0 1",
               err0, dut0.cnt[3], dut0.cnt[2]);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (err0 !== 1'b1) begin
      errors++;
      $display("FAIL bad_sticky: err=%b, required 1", err0);
    end
  endtask

  task automatic test_outreg_throughput();
    do_reset1();
    for (int i = 0; i < 4; i++)
      exp_q.push_back(txn_t'({2'(i), 8'hB0 + 8'(i)}));
    slv_valid1 = 4'hF;
    mst_ready1 = 1'b1;
    @(negedge clk);
    checks++;
    if (mst_valid1 !== 1'b0) begin
      errors++;
      $display("FAIL or_latency: mst_valid=%b, required 0", mst_valid1);
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (mst_valid1 !== 1'b1 || mst_idx1 !== e.idx || mst_data1 !== e.data) begin
        errors++;
        $display("FAIL or_stream: beat %0d valid=%b idx=%0d data=%h, required 1 %0d %h",
                 k, mst_valid1, mst_idx1, mst_data1, e.idx, e.data);
      end
    end
    @(posedge clk); #1;
    slv_valid1 = '0;
  endtask

  task automatic test_outreg_reset();
    do_reset1();
    slv_valid1 = 4'b0001;
    mst_ready1 = 1'b0;
    @(negedge clk);
    checks++;
    if (mst_valid1 !== 1'b0) begin
      errors++;
      $display("FAIL orr_latency: mst_valid=%b, required 0", mst_valid1);
    end
    @(posedge clk); #1;
    slv_valid1 = '0;
    @(negedge clk);
    checks++;
    if (mst_valid1 !== 1'b1 || mst_idx1 !== 2'd0 || dut1.cnt[0] !== 3'd1) begin
      errors++;
      $display("FAIL orr_stall: valid=%b idx=%0d cnt0=%0d, required 1 0 1",
               mst_valid1, mst_idx1, dut1.cnt[0]);
    end
    rstn1 = 1'b0;
    #1;
    checks++;
    if (mst_valid1 !== 1'b0 || dut1.ptr !== 2'd0 || dut1.cnt[0] !== 3'd0 ||
        dut1.cnt[1] !== 3'd0 || dut1.cnt[2] !== 3'd0 || dut1.cnt[3] !== 3'd0) begin
      errors++;
      $display("FAIL orr_async: valid=%b ptr=%0d cnt0=%0d, required 0 0 0",
               mst_valid1, dut1.ptr, dut1.cnt[0]);
    end
    @(posedge clk); #1;
    rstn1 = 1'b1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rstn0 = 1'b0;
    rstn1 = 1'b0;
    slv_valid0 = '0;
    slv_valid1 = '0;
    mst_ready0 = 1'b0;
    mst_ready1 = 1'b0;
    rsp_valid0 = 1'b0;
    rsp_valid1 = 1'b0;
    rsp_idx0 = '0;
    rsp_idx1 = '0;
    for (int i = 0; i < 4; i++) begin
      slv_data0[i] = 8'hA0 + 8'(i);
      slv_data1[i] = 8'hB0 + 8'(i);
    end
    @(posedge clk); #1;
    test_reset();
    test_round_robin();
    test_backpressure();
    test_inflight_limit();
    test_simul_retire();
    test_bad_retire();
    test_reset();
    test_outreg_throughput();
    test_outreg_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/xadac_req_arbiter.md
# xadac_req_arbiter

Round-robin arbiter that shares one downstream valid/ready request channel among `NumReq` upstream requesters in the xadac accelerator interface. It also enforces a per-requester in-flight limit, tracked from a response-retire port. It sits between the requester front-ends and the single execution or issue channel. Optionally, it drives that channel through one skid register stage.

## Interface
- `NumReq`, 4: number of requesters; must be ≥2.
- `MaxInflight`, 4: maximum accepted-but-unretired requests per requester; must be ≥1.
- `OutReg`, 0: 1 inserts one `xadac_skid` stage (non-passthrough) on the master side.
- `DataT`, logic: request payload type.
- `IdxW`, derived: `$clog2(NumReq)`; not overridable.
- `clk`  in  1  clock.
- `rstn`  in  1  reset, asynchronous, active-low.
- `slv_data`  in  NumReq×DataT  per-requester payload.
- `slv_valid`  in  NumReq  per-requester valid.
- `slv_ready`  out  NumReq  per-requester ready.
- `mst_data`  out  DataT  granted payload.
- `mst_idx`  out  IdxW  index of the granted requester, travels with `mst_data`.
- `mst_valid`  out  1  master valid.
- `mst_ready`  in  1  master ready.
- `rsp_valid`  in  1  retire pulse; always accepted; one retire per cycle.
- `rsp_idx`  in  IdxW  requester whose oldest in-flight request retires.
- `inflight_full`  out  NumReq  `cnt[i] == MaxInflight`.
- `err`  out  1  sticky flag: retire seen for a requester with `cnt == 0`.

## Operation
- State:
  - Priority pointer `ptr` (IdxW).
  - Lock flag `lock` plus locked index `lidx`.
  - Per-requester counters `cnt[i]`, width `$clog2(MaxInflight+1)`.
  - `err`.
- Eligibility: `elig[i] = slv_valid[i] && cnt[i] < MaxInflight`.
- Winner: first eligible index scanning `ptr`, `ptr+1`, … modulo `NumReq`. If `lock` is set, the winner is `lidx` regardless of eligibility.
- Internal channel: `int_valid = lock || |elig`. Data and index come from the winner.
- `slv_ready[i] = int_ready && (winner == i) && int_valid`. All other requesters see ready = 0.
- Lock rules:
  - Set when `int_valid && !int_ready`, with `lidx <= winner`.
  - Cleared on the internal handshake.
  - Together these guarantee a presented request is never withdrawn or switched: AXI-style valid stability downstream.
- On internal handshake (`int_valid && int_ready`):
  - `ptr <= (winner == NumReq-1) ? 0 : winner+1`.
  - `cnt[winner]` increments.
- On `rsp_valid`:
  - If `cnt[rsp_idx] > 0`, it decrements.
  - Otherwise the counter is unchanged and `err <= 1`.
  - `rsp_idx ≥ NumReq` is treated the same as the `cnt == 0` case.
- Same-cycle handshake and retire on the same index: net count unchanged; no overflow or underflow.
- Retire on a full requester in the same cycle as arbitration: eligibility uses the registered `cnt` only. The freed slot is usable the next cycle.
- `OutReg = 0`: `int_*` connects directly to `mst_*`.
- `OutReg = 1`: `int_*` feeds the `xadac_skid` slave side; `mst_*` is its master side.

## Timing
- Reset values:
  - `ptr = 0`, `lock = 0`, `lidx = 0`, all `cnt = 0`, `err = 0`.
  - `mst_valid = 0`, `slv_ready = 0` (with no valid present), `inflight_full = 0`.
- Latency:
  - `OutReg = 0`: 0 cycles, combinational valid to `mst_valid`.
  - `OutReg = 1`: 1 cycle. Full throughput of one request per cycle while `mst_ready` is held high.
- `slv_ready` is combinational from `mst_ready` only when `OutReg = 0`.
- Counter, pointer and `err` updates are visible the cycle after the triggering edge.
- Reset mid-operation: all state clears immediately (asynchronous). In-flight counts are lost, so requesters must reset together with the arbiter.

## Structure
- Shared package `xadac_pkg`: `xadac_idx_t` (requester index type), default `NumReq` and `MaxInflight` constants.
- Single sub-module: the existing `xadac_skid`, instantiated only under `OutReg`.
- Arbitration is a rotate, priority-encode, un-rotate sequence written inline.
- Counters are a generate loop; no separate module.

## Test plan
- **Round-robin:** `NumReq = 4`, all valid, `mst_ready = 1` → grants 0,1,2,3,0 on consecutive cycles; `mst_idx` matches.
- **Backpressure lock:** req1 and req2 valid, `mst_ready = 0` for 3 cycles → `mst_idx = 1` and data stable all 3 cycles. Grant to 1 on release, then 2.
- **In-flight limit:** `MaxInflight = 2`, only req0 valid, no retires → exactly 2 handshakes, then `slv_ready[0] = 0` and `inflight_full[0] = 1`. One `rsp_valid` with `rsp_idx = 0` → one more grant on the next cycle.
- **Simultaneous handshake and retire on idx 2**, `cnt = 1` → `cnt` stays 1.
- **Bad retire:** retire idx 3 with `cnt = 0` → `err = 1` next cycle and stays high until reset; counters unchanged.
- **`OutReg = 1`, reset mid-stall:** `mst_valid` appears 1 cycle after `slv_valid`. Assert `rstn = 0` while `mst_valid = 1` and `mst_ready = 0` → `mst_valid = 0`, `ptr = 0`, all `cnt = 0` immediately.
